lsu_bus_bridge: RTL and testbench

- Load/store responder for the core's memory-access stage.
- Accepts the M-stage request: read/write enable, funct3, address and store data.
- Converts it into a single-outstanding request/grant/response transaction on the data bus, with byte-lane steering, and returns aligned, sign- or zero-extended load data.
- Holds the pipeline with o_ex_stall while a transaction is in flight.

---
 rtl/lsu_bus_if.sv | 24 ++
 rtl/lsu_bus_bridge.sv | 175 +++++++++++++++++
 tb/tb_lsu_bus_bridge.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_bus_if.sv
// Data-bus channel between the load/store bridge (master) and the memory side (slave).
// Single outstanding request/grant/response; rvalid doubles as the write ack.
interface lsu_bus_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              gnt;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              rvalid;
    logic [31:0]       rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/lsu_bus_bridge.sv
// M-stage load/store bridge: lane steering, single-outstanding bus transaction, load extension.
// Define LSU_TIMEOUT_EN to abort REQ/WAIT after TIMEOUT_CYC cycles with a fault pulse.
module lsu_bus_bridge #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_m_read_en,
    input  logic        i_m_write_en,
    input  logic [2:0]  i_m_funct3,
    input  logic [31:0] i_m_addr,
    input  logic [31:0] i_m_wdata,
    output logic [31:0] o_m_memdata,
    output logic        o_ex_stall,
    output logic        o_fault,
    lsu_bus_if.master   bus
);
    // state  | meaning
    // IDLE   | waiting for an M-stage access
    // REQ    | bus request valid, waiting for grant
    // WAIT   | granted, waiting for rvalid
    // DONE   | completing instruction still held; ignore it for one cycle
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t            state_q;
    logic              req_q;
    logic              we_q;
    logic              fault_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       memdata_q;
    logic [2:0]        funct3_q;
    logic [1:0]        lane_q;

    logic              req_any;
    logic              legal_d;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d;
    logic [31:0]       shifted_d;
    logic [31:0]       fmt_d;
    logic              timeout_d;

    assign req_any = i_m_read_en | i_m_write_en;

    always_comb begin
        legal_d = 1'b0;
        be_d    = 4'b0000;
        wdata_d = i_m_wdata;
        case (i_m_funct3)
            3'b000, 3'b100: begin
                legal_d = 1'b1;
                be_d    = 4'b0001 << i_m_addr[1:0];
                wdata_d = {4{i_m_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                legal_d = ~i_m_addr[0];
                be_d    = 4'b0011 << {i_m_addr[1], 1'b0};
                wdata_d = {2{i_m_wdata[15:0]}};
            end
            3'b010: begin
                legal_d = (i_m_addr[1:0] == 2'b00);
                be_d    = 4'b1111;
            end
            default: ;
        endcase
        if (i_m_read_en && i_m_write_en) begin
            legal_d = 1'b0;
        end
    end

    always_comb begin
        shifted_d = bus.rdata >> {lane_q, 3'b000};
        case (funct3_q)
            3'b000:  fmt_d = {{24{shifted_d[7]}}, shifted_d[7:0]};
            3'b001:  fmt_d = {{16{shifted_d[15]}}, shifted_d[15:0]};
            3'b100:  fmt_d = {24'h000000, shifted_d[7:0]};
            3'b101:  fmt_d = {16'h0000, shifted_d[15:0]};
            default: fmt_d = shifted_d;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    assign timeout_d = ((state_q == S_REQ) || (state_q == S_WAIT)) && (cnt_q == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end
`else
    assign timeout_d = 1'b0;
`endif

    assign o_ex_stall = (state_q == S_REQ) || (state_q == S_WAIT) ||
                        ((state_q == S_IDLE) && req_any && legal_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            fault_q   <= 1'b0;
            addr_q    <= '0;
            be_q      <= 4'b0000;
            wdata_q   <= 32'h0;
            memdata_q <= 32'h0;
            funct3_q  <= 3'b000;
            lane_q    <= 2'b00;
        end else begin
            fault_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_any && legal_d) begin
                        addr_q   <= {i_m_addr[ADDR_W-1:2], 2'b00};
                        we_q     <= i_m_write_en;
                        be_q     <= be_d;
                        wdata_q  <= wdata_d;
                        funct3_q <= i_m_funct3;
                        lane_q   <= i_m_addr[1:0];
                        req_q    <= 1'b1;
                        state_q  <= S_REQ;
                    end else if (req_any) begin
                        // Illegal access: go to DONE so the held instruction cannot re-fault.
                        fault_q   <= 1'b1;
                        memdata_q <= 32'h0;
                        state_q   <= S_DONE;
                    end
                end
                S_REQ: begin
                    if (bus.gnt) begin
                        req_q   <= 1'b0;
                        state_q <= S_WAIT;
                    end else if (timeout_d) begin
                        req_q     <= 1'b0;
                        fault_q   <= 1'b1;
                        memdata_q <= 32'h0;
                        state_q   <= S_DONE;
                    end
                end
                S_WAIT: begin
                    if (bus.rvalid) begin
                        if (!we_q) begin
                            memdata_q <= fmt_d;
                        end
                        state_q <= S_DONE;
                    end else if (timeout_d) begin
                        fault_q   <= 1'b1;
                        memdata_q <= 32'h0;
                        state_q   <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req     = req_q;
    assign bus.we      = we_q;
    assign bus.addr    = addr_q;
    assign bus.be      = be_q;
    assign bus.wdata   = wdata_q;
    assign o_m_memdata = memdata_q;
    assign o_fault     = fault_q;
endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed bench for lsu_bus_bridge: loads, stores, faults, bus stalls, reset mid-transaction.
module tb_lsu_bus_bridge;
    logic        clk;
    logic        rst;
    logic        i_m_read_en;
    logic        i_m_write_en;
    logic [2:0]  i_m_funct3;
    logic [31:0] i_m_addr;
    logic [31:0] i_m_wdata;
    logic [31:0] o_m_memdata;
    logic        o_ex_stall;
    logic        o_fault;

    int n_total = 0;
    int n_bad   = 0;

    lsu_bus_if #(.ADDR_W(32)) bus ();

    lsu_bus_bridge #(.ADDR_W(32), .TIMEOUT_CYC(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_m_read_en  (i_m_read_en),
        .i_m_write_en (i_m_write_en),
        .i_m_funct3   (i_m_funct3),
        .i_m_addr     (i_m_addr),
        .i_m_wdata    (i_m_wdata),
        .o_m_memdata  (o_m_memdata),
        .o_ex_stall   (o_ex_stall),
        .o_fault      (o_fault),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef LSU_TIMEOUT_EN
    localparam int GD = 3;
    localparam int RD = 2;
`else
    localparam int GD = 5;
    localparam int RD = 3;
`endif

    typedef struct {
        int          stall;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic        stable;
        logic [31:0] memdata;
        logic        fault;
        logic        dstall;
        logic        done;
    } xfer_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the IDLE cycle after DONE.
    task automatic run_xfer(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                            output xfer_t r);
        int   req_cyc  = 0;
        int   wait_cyc = 0;
        bit   granted  = 0;
        bit   rv_sent  = 0;
        bit   got_req  = 0;
        r.stall = 0; r.addr = '0; r.be = '0; r.wdata = '0; r.we = 1'b0;
        r.stable = 1'b1; r.memdata = '0; r.fault = 1'b0; r.dstall = 1'b1; r.done = 1'b0;
        i_m_read_en = rd; i_m_write_en = wr; i_m_funct3 = f3; i_m_addr = addr; i_m_wdata = wd;
        for (int i = 0; i < 64; i++) begin
            #1;
            bus.gnt = 1'b0;
            bus.rvalid = 1'b0;
            if (o_fault) r.fault = 1'b1;
            if (rv_sent) begin
                r.memdata = o_m_memdata;
                r.dstall  = o_ex_stall;
                r.done    = 1'b1;
                break;
            end
            if (o_ex_stall) r.stall++;
            if (bus.req) begin
                if (!got_req) begin
                    got_req = 1; r.addr = bus.addr; r.be = bus.be; r.wdata = bus.wdata; r.we = bus.we;
                end else if (r.addr !== bus.addr || r.be !== bus.be ||
                             r.wdata !== bus.wdata || r.we !== bus.we) begin
                    r.stable = 1'b0;
                end
                if (req_cyc == gnt_dly) begin
                    bus.gnt = 1'b1;
                    granted = 1;
                end
                req_cyc++;
            end else if (granted) begin
                if (wait_cyc == rv_dly) begin
                    bus.rvalid = 1'b1;
                    bus.rdata  = rdata;
                    rv_sent    = 1;
                end
                wait_cyc++;
            end
            @(negedge clk);
        end
        i_m_read_en = 1'b0;
        i_m_write_en = 1'b0;
        bus.gnt = 1'b0;
        bus.rvalid = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_xfer(input string tag, input xfer_t r, input logic [31:0] e_addr,
                            input logic [3:0] e_be, input logic e_we, input logic [31:0] e_wd,
                            input logic [31:0] e_mem, input int e_stall);
        chk({tag, "_done"}, r.done, 1);
        chk({tag, "_addr"}, r.addr, e_addr);
        chk({tag, "_be"}, r.be, e_be);
        chk({tag, "_we"}, r.we, e_we);
        if (e_we) chk({tag, "_wdata"}, r.wdata, e_wd);
        chk({tag, "_memdata"}, r.memdata, e_mem);
        chk({tag, "_stall"}, r.stall, e_stall);
        chk({tag, "_stable"}, r.stable, 1);
        chk({tag, "_fault"}, r.fault, 0);
        chk({tag, "_done_stall"}, r.dstall, 0);
    endtask

    // Called at a negedge with an illegal access.
    task automatic fault_case(input string tag, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] addr);
        i_m_read_en = rd; i_m_write_en = wr; i_m_funct3 = f3; i_m_addr = addr; i_m_wdata = 32'h5A5A5A5A;
        #1;
        chk({tag, "_stall0"}, o_ex_stall, 0);
        chk({tag, "_req0"}, bus.req, 0);
        @(negedge clk); #1;
        chk({tag, "_fault"}, o_fault, 1);
        chk({tag, "_memdata"}, o_m_memdata, 32'h0);
        chk({tag, "_stall1"}, o_ex_stall, 0);
        chk({tag, "_req1"}, bus.req, 0);
        i_m_read_en = 1'b0; i_m_write_en = 1'b0;
        @(negedge clk); #1;
        chk({tag, "_fault_end"}, o_fault, 0);
        chk({tag, "_req2"}, bus.req, 0);
        @(negedge clk);
    endtask

    initial begin
        xfer_t r;
        rst = 1'b1;
        i_m_read_en = 1'b0; i_m_write_en = 1'b0; i_m_funct3 = 3'b000;
        i_m_addr = 32'h0; i_m_wdata = 32'h0;
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_req", bus.req, 0);
        chk("rst_memdata", o_m_memdata, 32'h0);
        chk("rst_stall", o_ex_stall, 0);
        chk("rst_fault", o_fault, 0);
        chk("rst_addr", bus.addr, 32'h0);
        chk("rst_be", bus.be, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_xfer(1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hCAFEBABE, r);
        chk_xfer("lw", r, 32'h100, 4'b1111, 0, 32'h0, 32'hCAFEBABE, 3);
        run_xfer(1, 0, 3'b000, 32'h203, 32'h0, 0, 0, 32'h80112233, r);
        chk_xfer("lb", r, 32'h200, 4'b1000, 0, 32'h0, 32'hFFFFFF80, 3);
        run_xfer(1, 0, 3'b100, 32'h203, 32'h0, 0, 0, 32'h80112233, r);
        chk_xfer("lbu", r, 32'h200, 4'b1000, 0, 32'h0, 32'h00000080, 3);
        run_xfer(1, 0, 3'b101, 32'h000, 32'h0, 0, 0, 32'h1234F00D, r);
        chk_xfer("lhu", r, 32'h000, 4'b0011, 0, 32'h0, 32'h0000F00D, 3);
        run_xfer(1, 0, 3'b001, 32'h202, 32'h0, 0, 0, 32'h80112233, r);
        chk_xfer("lh", r, 32'h200, 4'b1100, 0, 32'h0, 32'hFFFF8011, 3);
        run_xfer(0, 1, 3'b001, 32'h12, 32'h0000ABCD, 0, 0, 32'h77777777, r);
        chk_xfer("sh", r, 32'h10, 4'b1100, 1, 32'hABCDABCD, 32'hFFFF8011, 3);
        run_xfer(0, 1, 3'b000, 32'h5, 32'h12345678, 0, 0, 32'h77777777, r);
        chk_xfer("sb", r, 32'h4, 4'b0010, 1, 32'h78787878, 32'hFFFF8011, 3);

        fault_case("lw_mis", 1, 0, 3'b010, 32'h101);
        i_m_funct3 = 3'b010; i_m_addr = 32'h8;
        run_xfer(1, 0, 3'b010, 32'h8, 32'h0, 0, 0, 32'h0BADF00D, r);
        chk_xfer("lw_refill", r, 32'h8, 4'b1111, 0, 32'h0, 32'h0BADF00D, 3);
        fault_case("rw_both", 1, 1, 3'b010, 32'h20);
        fault_case("sh_mis", 0, 1, 3'b001, 32'h33);
        fault_case("f3_bad", 1, 0, 3'b011, 32'h40);

        run_xfer(1, 0, 3'b010, 32'h40, 32'h0, GD, RD, 32'h13579BDF, r);
        chk_xfer("lw_slow", r, 32'h40, 4'b1111, 0, 32'h0, 32'h13579BDF, 1 + (GD + 1) + (RD + 1));

        // Reset while in WAIT, then a stray rvalid.
        i_m_read_en = 1'b1; i_m_funct3 = 3'b010; i_m_addr = 32'h80;
        @(negedge clk); #1;
        chk("rstw_req_up", bus.req, 1);
        bus.gnt = 1'b1;
        @(negedge clk); #1;
        bus.gnt = 1'b0;
        chk("rstw_in_wait", bus.req, 0);
        chk("rstw_stall_wait", o_ex_stall, 1);
        i_m_read_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstw_req", bus.req, 0);
        chk("rstw_stall", o_ex_stall, 0);
        chk("rstw_memdata", o_m_memdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.rvalid = 1'b1; bus.rdata = 32'hDEADBEEF;
        @(negedge clk);
        bus.rvalid = 1'b0;
        #1;
        chk("rstw_late_memdata", o_m_memdata, 32'h0);
        chk("rstw_late_stall", o_ex_stall, 0);
        chk("rstw_late_req", bus.req, 0);
        @(negedge clk);
        run_xfer(1, 0, 3'b010, 32'h104, 32'h0, 0, 0, 32'h01020304, r);
        chk_xfer("lw_after_rst", r, 32'h104, 4'b1111, 0, 32'h0, 32'h01020304, 3);

`ifdef LSU_TIMEOUT_EN
        begin
            int req_cnt = 0;
            i_m_read_en = 1'b1; i_m_funct3 = 3'b010; i_m_addr = 32'h300;
            for (int i = 0; i < 40; i++) begin
                #1;
                if (bus.req) req_cnt++;
                else if (req_cnt > 0) break;
                @(negedge clk);
            end
            chk("to_req_cycles", req_cnt, 8);
            chk("to_fault", o_fault, 1);
            chk("to_stall", o_ex_stall, 0);
            chk("to_memdata", o_m_memdata, 32'h0);
            i_m_read_en = 1'b0;
            @(negedge clk); #1;
            chk("to_fault_end", o_fault, 0);
            @(negedge clk);
        end
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
